// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Packs a valid/ready byte stream little-endian into 32-bit words, writes
// them to consecutive word-aligned addresses from 0, and holds the CPU in
// reset until the image (terminated by in_last) has been written.
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             reload,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             load_done,
  output logic [IDX_W:0]   words_loaded,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      byteCnt_q, byteCnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [IDX_W:0]  wordIdx_q, wordIdx_d;
  logic            last_q, last_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     memAddr_q, memAddr_d;
  logic [31:0]     memWdata_q, memWdata_d;
  logic            loadDone_q, loadDone_d;

  logic            accept;
  logic            memFull;
  logic            wordEnds;
  logic [31:0]     asmWithByte;

  assign accept   = in_valid && in_ready;
  assign memFull  = (wordIdx_q == (IDX_W + 1)'(DEPTH_WORDS));
  assign wordEnds = (byteCnt_q == 2'd3) || in_last;

  // Drop the incoming byte into the lane selected by byteCnt.
  always_comb begin
    asmWithByte = asm_q;
    case (byteCnt_q)
      2'd0:    asmWithByte[7:0]   = in_data;
      2'd1:    asmWithByte[15:8]  = in_data;
      2'd2:    asmWithByte[23:16] = in_data;
      default: asmWithByte[31:24] = in_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic; once memory is full, bytes are swallowed until in_last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (memFull) begin
            if (in_last) state_d = ST_DONE;
          end else if (wordEnds) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = last_q ? ST_DONE : ST_LOAD;
      ST_DONE:  if (reload) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // Datapath next values: word assembly, write latch, counters, overflow.
  always_comb begin
    byteCnt_d  = byteCnt_q;
    asm_d      = asm_q;
    wordIdx_d  = wordIdx_q;
    last_d     = last_q;
    overflow_d = overflow_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (memFull) begin
            overflow_d = 1'b1;
          end else begin
            asm_d     = asmWithByte;
            byteCnt_d = byteCnt_q + 2'd1;
            if (wordEnds) begin
              memAddr_d  = {{(29 - IDX_W){1'b0}}, wordIdx_q, 2'b00};
              memWdata_d = asmWithByte;
              last_d     = in_last;
            end
          end
        end
      end
      ST_WRITE: begin
        wordIdx_d = wordIdx_q + 1'b1;
        asm_d     = 32'd0;
        byteCnt_d = 2'd0;
      end
      ST_DONE: begin
        if (reload) begin
          wordIdx_d  = '0;
          overflow_d = 1'b0;
          asm_d      = 32'd0;
          byteCnt_d  = 2'd0;
          last_d     = 1'b0;
        end
      end
      default: ;
    endcase
    loadDone_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // Datapath registers; reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      byteCnt_q  <= 2'd0;
      asm_q      <= 32'd0;
      wordIdx_q  <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      memAddr_q  <= 32'd0;
      memWdata_q <= 32'd0;
      loadDone_q <= 1'b0;
    end else begin
      byteCnt_q  <= byteCnt_d;
      asm_q      <= asm_d;
      wordIdx_q  <= wordIdx_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      loadDone_q <= loadDone_d;
    end
  end

  // Outputs; rst masks handshake and strobes so nothing moves during reset.
  always_comb begin
    in_ready     = (state_q == ST_LOAD) && !rst;
    mem_we       = (state_q == ST_WRITE) && !rst;
    cpu_hold     = (state_q != ST_DONE) || rst;
    load_done    = loadDone_q && !rst;
    mem_addr     = memAddr_q;
    mem_wdata    = memWdata_q;
    words_loaded = wordIdx_q;
    overflow     = overflow_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// A small memory (4 words) is used so the overflow path is reachable.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int IDX_W = 2;

  typedef logic [7:0] byteQ_t[$];

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_last;
  logic           in_ready;
  logic           reload;
  logic           mem_we;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic           cpu_hold;
  logic           load_done;
  logic [IDX_W:0] words_loaded;
  logic           overflow;

  int checks = 0;
  int passes = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int acceptCnt = 0;
  int protoViol = 0;

  imem_loader #(.DEPTH_WORDS(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .reload(reload),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done),
    .words_loaded(words_loaded), .overflow(overflow)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Passive monitor: records writes, accepted bytes and handshake violations.
  always @(negedge clk) begin
    if (mem_we) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
      if (mem_addr[1:0] != 2'b00) protoViol++;
    end
    if (in_valid && in_ready) acceptCnt++;
    if (in_ready && (mem_we || !cpu_hold)) protoViol++;
  end

  task automatic startCapture();
    wrAddr.delete();
    wrData.delete();
    acceptCnt = 0;
    protoViol = 0;
  endtask

  // Offer one byte after 0..gapMax idle cycles; returns at posedge+1 after acceptance.
  task automatic sendByte(input logic [7:0] b, input logic last, input int gapMax, input string tag);
    int waited;
    repeat ($urandom_range(gapMax, 0)) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(1, 0));
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        checks++;
        $display("[TB] FAIL %s ready_timeout: in_ready stayed 0 for %0d cycles, required 1", tag, waited);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sendImage(input byteQ_t img, input int gapMax, input string tag);
    for (int i = 0; i < img.size(); i++)
      sendByte(img[i], (i == img.size() - 1), gapMax, tag);
  endtask

  // Reference model: pack bytes LE into words, zero-fill the tail, truncate at DEPTH.
  task automatic checkImage(input byteQ_t img, input string tag);
    int n, nWords, expWrites;
    logic expOvf;
    logic [31:0] w;
    n         = img.size();
    nWords    = (n + 3) / 4;
    expOvf    = (nWords > DEPTH);
    expWrites = expOvf ? DEPTH : nWords;
    if (!expOvf) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1) $display("[TB] FAIL %s last_write_latency: mem_we=%b required 1", tag, mem_we);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1) $display("[TB] FAIL %s done_pulse: load_done=%b required 1", tag, load_done);
    else passes++;
    checks++;
    if (cpu_hold !== 1'b0) $display("[TB] FAIL %s hold_release: cpu_hold=%b required 0", tag, cpu_hold);
    else passes++;
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0) $display("[TB] FAIL %s done_one_cycle: load_done=%b required 0", tag, load_done);
    else passes++;
    checks++;
    if (wrAddr.size() !== expWrites) $display("[TB] FAIL %s write_count: got %0d required %0d", tag, wrAddr.size(), expWrites);
    else passes++;
    for (int k = 0; k < expWrites && k < wrAddr.size(); k++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) w = w | (32'(img[4 * k + j]) << (8 * j));
      checks++;
      if (wrAddr[k] !== 32'(4 * k)) $display("[TB] FAIL %s addr[%0d]: got %h required %h", tag, k, wrAddr[k], 32'(4 * k));
      else passes++;
      checks++;
      if (wrData[k] !== w) $display("[TB] FAIL %s data[%0d]: got %h required %h", tag, k, wrData[k], w);
      else passes++;
    end
    checks++;
    if (overflow !== expOvf) $display("[TB] FAIL %s overflow: got %b required %b", tag, overflow, expOvf);
    else passes++;
    checks++;
    if (words_loaded !== (IDX_W + 1)'(expWrites)) $display("[TB] FAIL %s words_loaded: got %0d required %0d", tag, words_loaded, expWrites);
    else passes++;
    checks++;
    if (acceptCnt !== n) $display("[TB] FAIL %s accepted_bytes: got %0d required %0d", tag, acceptCnt, n);
    else passes++;
    checks++;
    if (protoViol !== 0) $display("[TB] FAIL %s handshake_rules: got %0d violations required 0", tag, protoViol);
    else passes++;
    @(posedge clk); #1;
  endtask

  // Pulse reload in DONE and confirm the loader reopens with cleared status.
  task automatic doReload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0) $display("[TB] FAIL %s hold_before_reload: cpu_hold=%b required 0", tag, cpu_hold);
    else passes++;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1) $display("[TB] FAIL %s hold_after_reload: cpu_hold=%b required 1", tag, cpu_hold);
    else passes++;
    checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL %s overflow_cleared: got %b required 0", tag, overflow);
    else passes++;
    checks++;
    if (words_loaded !== '0) $display("[TB] FAIL %s words_cleared: got %0d required 0", tag, words_loaded);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL %s ready_after_reload: got %b required 1", tag, in_ready);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; reload = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset in_ready: got %b required 0", in_ready); else passes++;
    checks++;
    if (mem_we !== 1'b0) $display("[TB] FAIL reset mem_we: got %b required 0", mem_we); else passes++;
    checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0)
      $display("[TB] FAIL reset mem_bus: got %h/%h required 0/0", mem_addr, mem_wdata);
    else passes++;
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0)
      $display("[TB] FAIL reset hold_done: got %b/%b required 1/0", cpu_hold, load_done);
    else passes++;
    checks++;
    if (words_loaded !== '0 || overflow !== 1'b0)
      $display("[TB] FAIL reset status: got %0d/%b required 0/0", words_loaded, overflow);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    byteQ_t img;
    time t0;
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    startCapture();
    t0 = $time;
    sendImage(img, 0, "basic");
    checks++;
    if (($time - t0) / 10 !== 9) $display("[TB] FAIL basic throughput: got %0d cycles required 9", ($time - t0) / 10);
    else passes++;
    checkImage(img, "basic");
  endtask

  task automatic test_partial();
    byteQ_t img;
    img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    doReload("partial");
    startCapture();
    sendImage(img, 0, "partial");
    checkImage(img, "partial");
  endtask

  task automatic test_overflow();
    byteQ_t img;
    for (int i = 1; i <= 20; i++) img.push_back(8'(i));
    doReload("overflow");
    startCapture();
    sendImage(img, 0, "overflow");
    checkImage(img, "overflow");
  endtask

  task automatic test_deadbeef();
    byteQ_t img;
    img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    doReload("deadbeef");
    startCapture();
    sendImage(img, 0, "deadbeef");
    checkImage(img, "deadbeef");
  endtask

  task automatic test_gaps();
    byteQ_t img;
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    doReload("gaps");
    startCapture();
    sendImage(img, 3, "gaps");
    checkImage(img, "gaps");
  endtask

  task automatic test_random();
    byteQ_t img;
    for (int r = 0; r < 6; r++) begin
      img.delete();
      repeat ($urandom_range(22, 1)) img.push_back(8'($urandom));
      doReload($sformatf("random%0d", r));
      startCapture();
      sendImage(img, 3, $sformatf("random%0d", r));
      checkImage(img, $sformatf("random%0d", r));
    end
  endtask

  task automatic test_reset_midload();
    byteQ_t img;
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    doReload("midload");
    startCapture();
    sendByte(8'hAA, 1'b0, 0, "midload");
    sendByte(8'hBB, 1'b0, 0, "midload");
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || in_ready !== 1'b0)
        $display("[TB] FAIL midload during_reset: we/ready=%b/%b required 0/0", mem_we, in_ready);
      else passes++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    acceptCnt = 0;
    sendImage(img, 0, "midload");
    checkImage(img, "midload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_overflow();
    test_deadbeef();
    test_gaps();
    test_random();
    test_reset_midload();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
